// File: rtl/mmio_pkg.sv
// Shared address map, read-source encoding and tx FIFO sizing for the cpu memory/I/O router.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mmio_pkg;

    // addr[17:16] value that selects the memory-mapped I/O window
    localparam logic [1:0] IO_BASE_HI = 2'b11;

    // I/O register offsets within the window (addr[2:0])
    localparam logic [2:0] IO_UART = 3'h0;
    localparam logic [2:0] IO_CLK  = 3'h4;

    // Default log2 depth of the UART transmit FIFO
    localparam int DEF_TX_DEPTH_LOG2 = 3;

    // Which source drives cpu_din in the cycle after a read
    typedef enum logic {
        SRC_RAM = 1'b0,
        SRC_IO  = 1'b1
    } src_e;

endpackage

// File: rtl/mem_io_router_tx_fifo.sv
// Generic synchronous FIFO: circular pointers plus an occupancy count, with a look-ahead count.
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: a push while full is dropped unless a pop frees a slot in the same cycle.
module tx_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [W-1:0]          push_dat,
    input  logic                  pop,
    output logic [W-1:0]          head_dat,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic [DEPTH_LOG2:0]   count_nxt
);

    localparam int                      DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]     FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]     CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0]   PTR_ONE  = 1;

    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign pop_ok   = pop & ~empty;
    assign push_ok  = push & (~full | pop_ok);
    assign head_dat = mem[rd_ptr];

    // Occupancy after this cycle's push/pop; simultaneous push and pop cancel out
    always_comb begin
        count_nxt = count;
        if (push_ok & ~pop_ok) begin
            count_nxt = count + CNT_ONE;
        end else if (pop_ok & ~push_ok) begin
            count_nxt = count - CNT_ONE;
        end
    end

    // Pointer and count state; reset empties the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_nxt;
        end
    end

    // Storage array; contents need no reset because the count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/mem_io_router.sv
// Decodes cpu byte accesses to RAM or the I/O window (UART tx/rx, cycle counter, halt); optional MMIO_CNT_SNAPSHOT_EN.
// Latency: read data returns on cpu_din exactly one cycle after the address; writes take effect at the clock edge.
// Backpressure: cpu_rdy is registered low once the tx FIFO will hold depth-1 or more, leaving room for one in-flight write.
module mem_io_router
    import mmio_pkg::*;
#(
    parameter int TX_DEPTH_LOG2 = DEF_TX_DEPTH_LOG2,
    parameter int CNT_W         = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  cpu_addr,
    input  logic [7:0]   cpu_dout,
    input  logic         cpu_wr,
    output logic [7:0]   cpu_din,
    output logic         cpu_rdy,
    output logic [16:0]  ram_addr,
    output logic [7:0]   ram_wdata,
    output logic         ram_we,
    input  logic [7:0]   ram_rdata,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_pop,
    output logic         halt
);

    localparam logic [TX_DEPTH_LOG2:0] RDY_LIMIT = (TX_DEPTH_LOG2 + 1)'((1 << TX_DEPTH_LOG2) - 1);
    localparam logic [CNT_W-1:0]       CNT_ONE   = 1;

    logic                     is_io;
    logic [2:0]               io_off;
    logic                     io_rd;
    logic                     io_wr;
    logic                     fifo_push;
    logic [7:0]               fifo_push_dat;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [TX_DEPTH_LOG2:0]   fifo_count;
    logic [TX_DEPTH_LOG2:0]   fifo_count_nxt;
    logic [7:0]               io_byte;
    logic [7:0]               io_q;
    src_e                     sel_q;
    logic [CNT_W-1:0]         cnt;
    logic                     unused_sig;

    assign unused_sig = ^{cpu_addr[31:18], fifo_full, fifo_count};

    assign is_io  = (cpu_addr[17:16] == IO_BASE_HI);
    assign io_off = cpu_addr[2:0];
    assign io_rd  = ~cpu_wr & is_io;
    assign io_wr  = cpu_wr & is_io;

    assign ram_addr  = cpu_addr[16:0];
    assign ram_wdata = cpu_dout;
    assign ram_we    = cpu_wr & ~is_io & ~rst;

    // A stalled cpu still presents the read, but the rx byte is only consumed when ready
    assign rx_pop = ~rst & io_rd & (io_off == IO_UART) & rx_valid & cpu_rdy;

    // UART data writes of 0x00 are discarded; a clock-register write queues a 0x00 terminator
    assign fifo_push     = io_wr & (((io_off == IO_UART) & (cpu_dout != 8'h00)) | (io_off == IO_CLK));
    assign fifo_push_dat = (io_off == IO_CLK) ? 8'h00 : cpu_dout;

    tx_fifo #(
        .DEPTH_LOG2 (TX_DEPTH_LOG2),
        .W          (8)
    ) u_tx_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_dat   (fifo_push_dat),
        .pop        (tx_ready),
        .head_dat   (tx_data),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count      (fifo_count),
        .count_nxt  (fifo_count_nxt)
    );

    assign tx_valid = ~fifo_empty;

`ifdef MMIO_CNT_SNAPSHOT_EN
    logic [CNT_W-1:0] snap;

    // Capture the whole counter on a low-byte read so the upper bytes form a tear-free word
    always_ff @(posedge clk) begin
        if (rst) begin
            snap <= '0;
        end else if (io_rd & (io_off == IO_CLK)) begin
            snap <= cnt;
        end
    end
`endif

    // Byte returned for an I/O read at the current offset
    always_comb begin
        io_byte = 8'h00;
        if (io_off == IO_UART) begin
            io_byte = rx_pop ? rx_data : 8'h00;
        end else if (io_off[2]) begin
`ifdef MMIO_CNT_SNAPSHOT_EN
            if (io_off == IO_CLK) begin
                io_byte = cnt[7:0];
            end else begin
                io_byte = snap[{io_off[1:0], 3'b000} +: 8];
            end
`else
            io_byte = cnt[{io_off[1:0], 3'b000} +: 8];
`endif
        end
    end

    // Read-return pipeline stage; writes leave the last read's source and byte intact
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= SRC_RAM;
            io_q  <= 8'h00;
        end else if (~cpu_wr) begin
            sel_q <= is_io ? SRC_IO : SRC_RAM;
            io_q  <= io_byte;
        end
    end

    assign cpu_din = rst ? 8'h00 : ((sel_q == SRC_RAM) ? ram_rdata : io_q);

    // Free-running cycle counter that stops once the program halts
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (~halt) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Sticky halt flag raised by any write to the clock register
    always_ff @(posedge clk) begin
        if (rst) begin
            halt <= 1'b0;
        end else if (io_wr & (io_off == IO_CLK)) begin
            halt <= 1'b1;
        end
    end

    // Registered ready, looking ahead at next-cycle FIFO occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdy <= 1'b1;
        end else begin
            cpu_rdy <= (fifo_count_nxt < RDY_LIMIT);
        end
    end

endmodule

// File: tb/tb_mem_io_router.sv
module tb_mem_io_router;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  cpu_addr;
    logic [7:0]   cpu_dout;
    logic         cpu_wr;
    logic [7:0]   cpu_din;
    logic         cpu_rdy;
    logic [16:0]  ram_addr;
    logic [7:0]   ram_wdata;
    logic         ram_we;
    logic [7:0]   ram_rdata = 8'h00;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_pop;
    logic         halt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ram_model [0:131071];

    always #5 clk = ~clk;

    // Behavioural RAM with a registered read port
    always @(posedge clk) begin
        if (ram_we) ram_model[ram_addr] <= ram_wdata;
        ram_rdata <= ram_model[ram_addr];
    end

    mem_io_router u_dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_wr    (cpu_wr),
        .cpu_din   (cpu_din),
        .cpu_rdy   (cpu_rdy),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_pop    (rx_pop),
        .halt      (halt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_addr = 32'h0000_0000;
        cpu_wr   = 1'b0;
        cpu_dout = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        cpu_addr = 32'h0000_0100; cpu_wr = 1'b1; cpu_dout = 8'hEE;
        tick();
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL reset_ram_we got=%0b want=0", ram_we); end
        n_cmp++; if (cpu_din !== 8'h00) begin n_bad++; $display("FAIL reset_cpu_din got=%02h want=00", cpu_din); end
        n_cmp++; if (cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_cpu_rdy got=%0b want=1", cpu_rdy); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid got=%0b want=0", tx_valid); end
        n_cmp++; if (halt !== 1'b0) begin n_bad++; $display("FAIL reset_halt got=%0b want=0", halt); end
        n_cmp++; if (rx_pop !== 1'b0) begin n_bad++; $display("FAIL reset_rx_pop got=%0b want=0", rx_pop); end
        idle();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ram();
        cpu_addr = 32'h0000_0100; cpu_wr = 1'b1; cpu_dout = 8'h5A;
        #1;
        n_cmp++; if (ram_we !== 1'b1) begin n_bad++; $display("FAIL ram_we got=%0b want=1", ram_we); end
        n_cmp++; if (ram_addr !== 17'h00100) begin n_bad++; $display("FAIL ram_addr got=%05h want=00100", ram_addr); end
        n_cmp++; if (ram_wdata !== 8'h5A) begin n_bad++; $display("FAIL ram_wdata got=%02h want=5a", ram_wdata); end
        tick();
        cpu_wr = 1'b0; cpu_dout = 8'h00;
        #1;
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL ram_we_read got=%0b want=0", ram_we); end
        tick();
        idle();
        n_cmp++; if (cpu_din !== 8'h5A) begin n_bad++; $display("FAIL ram_read got=%02h want=5a", cpu_din); end
    endtask

    task automatic test_tx_filter();
        tx_ready = 1'b1;
        cpu_addr = 32'h0003_0000; cpu_wr = 1'b1; cpu_dout = 8'h41;
        tick();
        n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin n_bad++; $display("FAIL tx_first got=%0b/%02h want=1/41", tx_valid, tx_data); end
        cpu_dout = 8'h00;
        tick();
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL tx_zero_dropped got=%0b want=0", tx_valid); end
        cpu_dout = 8'h42;
        tick();
        n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin n_bad++; $display("FAIL tx_second got=%0b/%02h want=1/42", tx_valid, tx_data); end
        idle();
        tick();
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL tx_drained got=%0b want=0", tx_valid); end
    endtask

    task automatic test_backpressure();
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cpu_addr = 32'h0003_0000; cpu_wr = 1'b1; cpu_dout = 8'(8'h61 + i);
            tick();
            if (i == 5) begin
                n_cmp++; if (cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL bp_rdy_after6 got=%0b want=1", cpu_rdy); end
            end
            if (i == 6) begin
                n_cmp++; if (cpu_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_rdy_after7 got=%0b want=0", cpu_rdy); end
            end
        end
        n_cmp++; if (tx_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid got=%0b want=1", tx_valid); end
        n_cmp++; if (u_dut.u_tx_fifo.count !== 4'd8) begin n_bad++; $display("FAIL bp_count got=%0d want=8", u_dut.u_tx_fifo.count); end
        cpu_dout = 8'h69;
        tick();
        n_cmp++; if (u_dut.u_tx_fifo.count !== 4'd8) begin n_bad++; $display("FAIL bp_overflow_count got=%0d want=8", u_dut.u_tx_fifo.count); end
        n_cmp++; if (cpu_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_rdy_full got=%0b want=0", cpu_rdy); end
        idle();
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(8'h61 + i)) begin
                n_bad++; $display("FAIL bp_drain%0d got=%0b/%02h want=1/%02h", i, tx_valid, tx_data, 8'(8'h61 + i));
            end
            tick();
        end
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty got=%0b want=0", tx_valid); end
        n_cmp++; if (cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL bp_rdy_back got=%0b want=1", cpu_rdy); end
    endtask

    task automatic test_rx();
        cpu_addr = 32'h0003_0000; cpu_wr = 1'b0; rx_valid = 1'b1; rx_data = 8'h33;
        #1;
        n_cmp++; if (rx_pop !== 1'b1) begin n_bad++; $display("FAIL rx_pop_pulse got=%0b want=1", rx_pop); end
        tick();
        idle(); rx_valid = 1'b0; rx_data = 8'h00;
        #1;
        n_cmp++; if (rx_pop !== 1'b0) begin n_bad++; $display("FAIL rx_pop_end got=%0b want=0", rx_pop); end
        n_cmp++; if (cpu_din !== 8'h33) begin n_bad++; $display("FAIL rx_data got=%02h want=33", cpu_din); end
        cpu_addr = 32'h0003_0000;
        #1;
        n_cmp++; if (rx_pop !== 1'b0) begin n_bad++; $display("FAIL rx_nopop got=%0b want=0", rx_pop); end
        tick();
        idle();
        n_cmp++; if (cpu_din !== 8'h00) begin n_bad++; $display("FAIL rx_empty_read got=%02h want=00", cpu_din); end
    endtask

    task automatic test_counter();
        logic [7:0] want [4];
        want[0] = 8'h03; want[1] = 8'h01; want[2] = 8'h00; want[3] = 8'h00;
        idle(); tx_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (32'h103) tick();
        for (int i = 0; i < 4; i++) begin
            cpu_addr = 32'h0003_0004 + 32'(i); cpu_wr = 1'b0;
            tick();
            n_cmp++;
            if (cpu_din !== want[i]) begin n_bad++; $display("FAIL cnt_byte%0d got=%02h want=%02h", i, cpu_din, want[i]); end
        end
    endtask

    task automatic test_halt();
        cpu_addr = 32'h0003_0004; cpu_wr = 1'b1; cpu_dout = 8'hAA;
        tick();
        idle();
        n_cmp++; if (halt !== 1'b1) begin n_bad++; $display("FAIL halt_set got=%0b want=1", halt); end
        n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin n_bad++; $display("FAIL halt_tx got=%0b/%02h want=1/00", tx_valid, tx_data); end
        repeat (5) tick();
        cpu_addr = 32'h0003_0004;
        tick();
        n_cmp++; if (cpu_din !== 8'h08) begin n_bad++; $display("FAIL halt_cnt_b0 got=%02h want=08", cpu_din); end
        cpu_addr = 32'h0003_0005;
        tick();
        n_cmp++; if (cpu_din !== 8'h01) begin n_bad++; $display("FAIL halt_cnt_b1 got=%02h want=01", cpu_din); end
        idle();
        tick();
        n_cmp++; if (halt !== 1'b1) begin n_bad++; $display("FAIL halt_sticky got=%0b want=1", halt); end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++) begin
            cpu_addr = 32'h0003_0000; cpu_wr = 1'b1; cpu_dout = 8'(8'h11 * (i + 1));
            tick();
        end
        idle();
        tx_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h22) begin n_bad++; $display("FAIL mid_drain_head got=%0b/%02h want=1/22", tx_valid, tx_data); end
        rst = 1'b1;
        cpu_addr = 32'h0000_0200; cpu_wr = 1'b1; cpu_dout = 8'h77;
        #1;
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL rst_ram_we got=%0b want=0", ram_we); end
        n_cmp++; if (cpu_din !== 8'h00) begin n_bad++; $display("FAIL rst_cpu_din got=%02h want=00", cpu_din); end
        tick();
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_tx_valid got=%0b want=0", tx_valid); end
        n_cmp++; if (halt !== 1'b0) begin n_bad++; $display("FAIL rst_halt got=%0b want=0", halt); end
        cpu_addr = 32'h0003_0000; cpu_wr = 1'b0; rx_valid = 1'b1; rx_data = 8'h55;
        #1;
        n_cmp++; if (rx_pop !== 1'b0) begin n_bad++; $display("FAIL rst_rx_pop got=%0b want=0", rx_pop); end
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        cpu_addr = 32'h0003_0004;
        tick();
        n_cmp++; if (cpu_din !== 8'h00) begin n_bad++; $display("FAIL rst_cnt_zero got=%02h want=00", cpu_din); end
        idle();
        tick();
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_fifo_empty got=%0b want=0", tx_valid); end
        n_cmp++; if (cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_rdy got=%0b want=1", cpu_rdy); end
    endtask

    initial begin
        idle();
        rst = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        test_reset();
        test_ram();
        test_tx_filter();
        test_backpressure();
        test_rx();
        test_counter();
        test_halt();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
